// File: rtl/signmag_display_pkg.sv
// Shared constants for the sign-magnitude 7-segment display block.
package signmag_display_pkg;

    // Shift-add-3 iterations needed for an 8-bit magnitude.
    localparam int ITERS = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [0:9][6:0] SEG_DIGIT = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/signmag_display_if.sv
// Load/status/display bundle between the producer and the display block.
interface signmag_display_if;
    logic       load;
    logic [8:0] value;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (output load, value, input busy, done, seg, an);
    modport slave  (input load, value, output busy, done, seg, an);
endinterface

// File: rtl/signmag_display_seg7_decode.sv
// Digit-to-segment lookup; minus wins over blank, values above 9 show blank.
module seg7_decode
    import signmag_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    // Pick the pattern for the currently selected scan slot.
    always_comb begin
        seg = SEG_BLANK;
        if (minus)
            seg = SEG_MINUS;
        else if (!blank && digit <= 4'd9)
            seg = SEG_DIGIT[digit];
    end

endmodule

// File: rtl/signmag_display.sv
// Sign-magnitude to 4-digit multiplexed 7-segment display with
// double-dabble conversion and a free-running digit scan.
module signmag_display
    import signmag_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    signmag_display_if.slave    bus
);

    localparam logic [15:0] DIV_M1 = 16'(SCAN_DIV - 1);

    // Conversion state
    state_t      state;
    logic [2:0]  iter;
    logic        sign_q;
    logic        mag_nz_q;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [7:0]  bin_nxt;
    logic [11:0] bcd_nxt;
    logic [11:0] bcd_adj;
    logic        busy_q;
    logic        done_q;

    // Committed display contents
    logic        disp_neg;
    logic        disp_hblank;
    logic        disp_tblank;
    logic [3:0]  disp_h;
    logic [3:0]  disp_t;
    logic [3:0]  disp_o;

    // Scan state
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    logic        wrap;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [3:0]  dec_digit;
    logic        dec_blank;
    logic        dec_minus;
    logic [6:0]  dec_seg;

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < 3; d++) begin
            if (bcd_adj[d*4 +: 4] >= 4'd5)
                bcd_adj[d*4 +: 4] = bcd_adj[d*4 +: 4] + 4'd3;
        end
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
    end

    // Conversion FSM; display registers only change on leaving COMMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter        <= '0;
            sign_q      <= 1'b0;
            mag_nz_q    <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            disp_neg    <= 1'b0;
            disp_hblank <= 1'b1;
            disp_tblank <= 1'b1;
            disp_h      <= '0;
            disp_t      <= '0;
            disp_o      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.load) begin
                        state    <= CONV;
                        busy_q   <= 1'b1;
                        sign_q   <= bus.value[8];
                        mag_nz_q <= |bus.value[7:0];
                        bin_q    <= bus.value[7:0];
                        bcd_q    <= '0;
                        iter     <= '0;
                    end
                end
                CONV: begin
                    bin_q <= bin_nxt;
                    bcd_q <= bcd_nxt;
                    iter  <= iter + 3'd1;
                    if (iter == 3'(ITERS - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    // Negative zero shows as plain 0.
                    disp_neg    <= sign_q & mag_nz_q;
                    disp_h      <= bcd_q[11:8];
                    disp_t      <= bcd_q[7:4];
                    disp_o      <= bcd_q[3:0];
                    disp_hblank <= (bcd_q[11:8] == 4'd0);
                    disp_tblank <= (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wrap    = (cnt == DIV_M1);
    assign idx_nxt = wrap ? idx + 2'd1 : idx;

    // Route the slot that will be active after this edge into the decoder,
    // so an and seg are registered together.
    always_comb begin
        dec_digit = 4'd0;
        dec_blank = 1'b1;
        dec_minus = 1'b0;
        unique case (idx_nxt)
            2'd0: begin dec_digit = disp_o; dec_blank = 1'b0;        end
            2'd1: begin dec_digit = disp_t; dec_blank = disp_tblank; end
            2'd2: begin dec_digit = disp_h; dec_blank = disp_hblank; end
            2'd3: begin dec_blank = ~disp_neg; dec_minus = disp_neg; end
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .digit (dec_digit),
        .blank (dec_blank),
        .minus (dec_minus),
        .seg   (dec_seg)
    );

    // Free-running prescaler and digit scan, independent of the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            an_q  <= 4'b1110;
            seg_q <= SEG_DIGIT[0];
        end else begin
            cnt   <= wrap ? 16'd0 : cnt + 16'd1;
            idx   <= idx_nxt;
            an_q  <= ~(4'b0001 << idx_nxt);
            seg_q <= dec_seg;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule

// File: tb/tb_signmag_display.sv
// Directed bench: scoreboard of expected digit patterns, scan model for an.
module tb_signmag_display;

    localparam logic [6:0] T_BLANK = 7'b1111111;
    localparam logic [6:0] T_MINUS = 7'b0111111;
    localparam logic [6:0] T_SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_cnt;
    logic [1:0] m_idx;
    logic [3:0][6:0] sb [$];

    signmag_display_if bus ();

    signmag_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scan: prescale 0..3, slot index advances on wrap.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_idx <= 2'd0;
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_idx <= m_idx + 2'd1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [3:0][6:0] exp_disp(input logic [8:0] v);
        logic [3:0][6:0] r;
        int mag, h, t, o;
        mag = int'(v[7:0]);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        r[0] = T_SEG[o];
        r[1] = (h == 0 && t == 0) ? T_BLANK : T_SEG[t];
        r[2] = (h == 0) ? T_BLANK : T_SEG[h];
        r[3] = (v[8] && mag != 0) ? T_MINUS : T_BLANK;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk one full scan (16 clocks), checking an and capturing seg per slot.
    task automatic read_disp(output logic [3:0][6:0] got);
        got = '1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("an_scan", {28'd0, bus.an}, {28'd0, ~(4'b0001 << m_idx)});
            got[m_idx] = bus.seg;
        end
    endtask

    task automatic compare_disp(input string tag, input logic [3:0][6:0] e);
        logic [3:0][6:0] got;
        read_disp(got);
        for (int s = 0; s < 4; s++)
            chk($sformatf("%s_slot%0d", tag, s), {25'd0, got[s]}, {25'd0, e[s]});
    endtask

    // Load v, optionally pulse a second load on edge k+late_at, and check
    // busy/done timing followed by the committed display.
    task automatic conv_check(input logic [8:0] v, input int late_at, input logic [8:0] late_v);
        logic [3:0][6:0] e;
        bus.load  = 1'b1;
        bus.value = v;
        sb.push_back(exp_disp(v));
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("busy_conv", {31'd0, bus.busy}, 32'd1);
            chk("done_conv", {31'd0, bus.done}, 32'd0);
            if (i + 1 == late_at) begin
                bus.load  = 1'b1;
                bus.value = late_v;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;
        chk("busy_commit", {31'd0, bus.busy}, 32'd0);
        chk("done_commit", {31'd0, bus.done}, 32'd1);
        tick();
        chk("done_once", {31'd0, bus.done}, 32'd0);
        chk("busy_after", {31'd0, bus.busy}, 32'd0);
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            compare_disp($sformatf("disp_%03h", v), e);
        end
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        // load during reset must not start anything
        bus.load  = 1'b1;
        bus.value = 9'h1FF;
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_an",   {28'd0, bus.an},   32'b1110);
        chk("rst_seg",  {25'd0, bus.seg},  32'b1000000);
        bus.load = 1'b0;
        rst_n    = 1'b1;

        // idle scan after reset
        compare_disp("idle", exp_disp(9'h000));
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        conv_check(9'h1FF, 0, 9'h000);   // -255
        conv_check(9'h007, 0, 9'h000);   // 7
        conv_check(9'h100, 0, 9'h000);   // negative zero
        conv_check(9'h00C, 2, 9'h1FF);   // second load while busy
        conv_check(9'h0C8, 9, 9'h005);   // 200; load on commit edge ignored
        conv_check(9'h163, 0, 9'h000);   // -99

        // reset at edge k+4 abandons conversion
        bus.load  = 1'b1;
        bus.value = 9'h064;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_an",  {28'd0, bus.an},  32'b1110);
        chk("abort_seg", {25'd0, bus.seg}, 32'b1000000);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_done", {31'd0, bus.done}, 32'd0);
            chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        end
        compare_disp("abort", exp_disp(9'h000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/signmag_display.md
SIGNMAG_DISPLAY -- requirements
Module: signmag_display

Interface
REQ-001 Parameter: SCAN_DIV, default 50000; clocks per digit slot of the display scan, legal range 2..65535.
REQ-002 clk  input  1  rising-edge clock for the whole block.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 load  input  1  one-cycle request to capture value.
REQ-005 value  input  9  sign-magnitude result from the subtractor: bit 8 is the sign (1 = negative), bits 7:0 are the magnitude 0..255.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when the new digits are committed to the display.
REQ-008 seg  output  7  active-low segment bits, ordered {g,f,e,d,c,b,a}.
REQ-009 an  output  4  active-low one-hot digit enable; an[3] is the leftmost (sign) digit and an[0] is the ones digit.

Function
REQ-010 FSM states: IDLE, CONV and COMMIT.
- IDLE -> CONV on the edge where load=1; value is captured into an internal register and busy=1.
- CONV -> COMMIT after exactly 8 shift-add-3 iterations, one per clock.
- COMMIT -> IDLE on the next edge.
REQ-011 Conversion method: binary-to-BCD double-dabble on the 8-bit magnitude.
- Three 4-bit BCD digits: hundreds (0..2), tens (0..9), ones (0..9).
- Add 3 to any digit >= 5 before each shift.
REQ-012 Latency: if load is sampled at edge k, the display registers update and done=1 at edge k+9; busy=1 from edge k through edge k+8 and busy=0 at edge k+9.
REQ-013 load while busy=1 is ignored; the captured value, the FSM and the timing are unaffected.
REQ-014 load on the same edge that busy falls (COMMIT -> IDLE) is ignored; only load sampled in IDLE starts a conversion.
REQ-015 Display contents and the done pulse do not change during CONV; the previous result keeps showing until COMMIT completes.
REQ-016 Leading-zero blanking:
- hundreds digit is blank when hundreds=0;
- tens digit is blank when hundreds=0 and tens=0;
- ones digit is always shown.
REQ-017 Sign digit:
- shows minus (segment g only, seg=7'b0111111) when sign=1 and magnitude is not 0;
- otherwise blank.
- Negative zero (9'h100) displays as plain 0.
REQ-018 Blank digit drives seg=7'b1111111.
REQ-019 Scan timing:
- a prescale counter counts 0..SCAN_DIV-1 and wraps;
- on each wrap the digit index advances 0->1->2->3->0;
- an and seg are registered and change on the same edge.
REQ-020 The scan runs continuously in every FSM state and is never stalled by load or busy.
REQ-021 The segment pattern for digit values above 9 is all blank; such values never occur in legal operation.

Reset
REQ-022 On an edge with rst_n=0, the following take their reset values:
- FSM state = IDLE;
- busy = 0 and done = 0;
- prescale counter = 0 and digit index = 0;
- an = 4'b1110;
- display registers hold sign blank, hundreds blank, tens blank and ones = 0, so seg = 7'b1000000.
REQ-023 Reset during CONV or COMMIT abandons the conversion: no done pulse, and the display returns to its reset contents.
REQ-024 load asserted together with rst_n=0 is ignored.

Structure
REQ-025 Shared package contents:
- the 7-segment patterns for digits 0..9, blank and minus;
- the FSM state typedef;
- the iteration count constant (8).
REQ-026 Sub-module seg7_decode: a combinational digit-to-segment lookup that also handles blank and minus; it is instantiated once, on the scan-selected digit.
REQ-027 All state is updated only on the clk rising edge; there are no latches and no other clocks.

Verification
REQ-028 Scenario, reset then idle with SCAN_DIV=4:
- an cycles 1110, 1101, 1011, 0111, changing every 4 clocks;
- seg shows 7'b1000000 in the ones slot and 7'b1111111 in the other slots.
REQ-029 Scenario, load value=9'h1FF (-255):
- busy is high for 9 edges, then done pulses exactly once;
- digits show minus, 2, 5, 5.
REQ-030 Scenario, load value=9'h007: digits show blank, blank, blank, 7; load value=9'h100 shows blank, blank, blank, 0 with no minus.
REQ-031 Scenario, load 9'h00C, then load 9'h1FF two cycles later while busy: the second load is ignored and the display shows blank, blank, 1, 2.
REQ-032 Scenario, load 9'h064, then rst_n=0 at edge k+4: no done pulse follows and the display returns to its reset contents.
REQ-033 Scenario, load 9'h0C8 (200): digits show blank, 2, 0, 0; tens 0 is shown because hundreds is not 0.
